// File: rtl/router_pkt_tx_if.sv
// Loader, start/status and router-side byte stream of the router 1x3 packet source.
// master is the transmitter; slave is the loader/router side.
interface router_pkt_tx_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic [5:0] ld_count;
  logic       ld_full;
  logic       start;
  logic [1:0] dest_addr;
  logic       tx_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       pkt_done;
  logic       cmd_err;
  logic       tx_timeout;

  modport master (
    input  ld_valid, ld_data, start, dest_addr, busy,
    output ld_count, ld_full, tx_ready, data_out, pkt_valid, pkt_done, cmd_err, tx_timeout
  );

  modport slave (
    output ld_valid, ld_data, start, dest_addr, busy,
    input  ld_count, ld_full, tx_ready, data_out, pkt_valid, pkt_done, cmd_err, tx_timeout
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffers up to MAX_LEN payload bytes, then sends header/payload/parity to the router
// under the busy/pkt_valid protocol, abandoning the packet after BUSY_TO busy cycles.
//
// state | meaning
// IDLE  | loading allowed, start accepted
// HDR   | header byte {len,addr} on data_out
// PLD   | payload byte pld_mem[idx] on data_out
// PAR   | parity byte on data_out, pkt_valid low
module router_pkt_tx #(
  parameter int MAX_LEN = 63,
  parameter int BUSY_TO = 30
) (
  input logic             clk,
  input logic             rst,
  router_pkt_tx_if.master bus
);

  localparam int            BW       = $clog2(BUSY_TO);
  localparam logic [5:0]    MAX_LEN_W = 6'(MAX_LEN);
  localparam logic [BW-1:0] BUSY_LIM = BW'(BUSY_TO - 1);

  typedef enum logic [1:0] {IDLE, HDR, PLD, PAR} state_t;

  state_t        state;
  logic [7:0]    pld_mem [64];
  logic [5:0]    ld_count;
  logic          ld_full;
  logic [5:0]    len;
  logic [5:0]    idx;
  logic [7:0]    parity;
  logic [7:0]    data_out;
  logic          pkt_valid;
  logic          pkt_done;
  logic          cmd_err;
  logic          tx_timeout;
  logic          tx_ready;
  logic [BW-1:0] busy_cnt;
  logic          ld_ok;

  assign ld_ok = (state == IDLE) && bus.ld_valid && (ld_count != MAX_LEN_W);

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (ld_ok) pld_mem[ld_count] <= bus.ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ld_count   <= '0;
      ld_full    <= 1'b0;
      len        <= '0;
      idx        <= '0;
      parity     <= '0;
      data_out   <= '0;
      pkt_valid  <= 1'b0;
      pkt_done   <= 1'b0;
      cmd_err    <= 1'b0;
      tx_timeout <= 1'b0;
      tx_ready   <= 1'b1;
      busy_cnt   <= '0;
    end else begin
      pkt_done   <= 1'b0;
      cmd_err    <= 1'b0;
      tx_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_ok) begin
            ld_count <= ld_count + 6'd1;
            ld_full  <= (ld_count + 6'd1) == MAX_LEN_W;
          end
          if (bus.start) begin
            if (bus.dest_addr == 2'd3 || ld_count == 6'd0) begin
              cmd_err <= 1'b1;
            end else begin
              // len is the count before any load on this same edge
              len       <= ld_count;
              data_out  <= {ld_count, bus.dest_addr};
              parity    <= {ld_count, bus.dest_addr};
              pkt_valid <= 1'b1;
              tx_ready  <= 1'b0;
              busy_cnt  <= '0;
              state     <= HDR;
            end
          end
        end
        default: begin
          if (bus.busy) begin
            if (busy_cnt == BUSY_LIM) begin
              state      <= IDLE;
              data_out   <= '0;
              pkt_valid  <= 1'b0;
              tx_timeout <= 1'b1;
              tx_ready   <= 1'b1;
              ld_count   <= '0;
              ld_full    <= 1'b0;
              busy_cnt   <= '0;
            end else begin
              busy_cnt <= busy_cnt + 1'b1;
            end
          end else begin
            busy_cnt <= '0;
            case (state)
              HDR: begin
                idx      <= '0;
                data_out <= pld_mem[0];
                state    <= PLD;
              end
              PLD: begin
                parity <= parity ^ data_out;
                if (idx == len - 6'd1) begin
                  data_out  <= parity ^ data_out;
                  pkt_valid <= 1'b0;
                  state     <= PAR;
                end else begin
                  idx      <= idx + 6'd1;
                  data_out <= pld_mem[idx + 6'd1];
                end
              end
              default: begin
                data_out <= '0;
                pkt_done <= 1'b1;
                tx_ready <= 1'b1;
                ld_count <= '0;
                ld_full  <= 1'b0;
                state    <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.ld_count   = ld_count;
  assign bus.ld_full    = ld_full;
  assign bus.tx_ready   = tx_ready;
  assign bus.data_out   = data_out;
  assign bus.pkt_valid  = pkt_valid;
  assign bus.pkt_done   = pkt_done;
  assign bus.cmd_err    = cmd_err;
  assign bus.tx_timeout = tx_timeout;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: normal packets, busy hold, rejects, full buffer,
// busy timeout boundary and asynchronous reset mid-packet.
module tb_router_pkt_tx;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] exp_q [$];
  logic seen_to;

  router_pkt_tx_if bus ();

  router_pkt_tx #(.MAX_LEN(63), .BUSY_TO(30)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] b);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    step();
    bus.ld_valid = 1'b0;
  endtask

  task automatic start_pkt(input logic [1:0] a);
    bus.start     = 1'b1;
    bus.dest_addr = a;
    step();
    bus.start     = 1'b0;
  endtask

  // Walks exp_q (header, payload..., parity) with busy low, then checks completion.
  task automatic run_pkt(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_data"}, bus.data_out, exp_q[i]);
      chk({tag, "_pv"}, bus.pkt_valid, (i == exp_q.size() - 1) ? 0 : 1);
      step();
    end
    chk({tag, "_done"}, bus.pkt_done, 1);
    chk({tag, "_cnt0"}, bus.ld_count, 0);
    chk({tag, "_rdy"}, bus.tx_ready, 1);
    chk({tag, "_dout0"}, bus.data_out, 0);
    chk({tag, "_noto"}, bus.tx_timeout, 0);
    step();
    chk({tag, "_done_pulse"}, bus.pkt_done, 0);
  endtask

  initial begin
    clk = 0; rst = 1; checks = 0; errors = 0;
    bus.ld_valid = 0; bus.ld_data = 0; bus.start = 0; bus.dest_addr = 0; bus.busy = 0;
    step(); step();
    chk("rst_dout", bus.data_out, 0);
    chk("rst_pv", bus.pkt_valid, 0);
    chk("rst_cnt", bus.ld_count, 0);
    chk("rst_rdy", bus.tx_ready, 1);
    chk("rst_full", bus.ld_full, 0);
    rst = 0;
    step();

    // 1: basic 3-byte packet to port 1
    load(8'hA1); load(8'hB2); load(8'hC3);
    chk("t1_cnt", bus.ld_count, 3);
    start_pkt(2'd1);
    chk("t1_rdy0", bus.tx_ready, 0);
    exp_q = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    run_pkt("t1");

    // 2: busy for 4 cycles while B2 is presented
    load(8'hA1); load(8'hB2); load(8'hC3);
    start_pkt(2'd1);
    chk("t2_hdr", bus.data_out, 8'h0D);
    step();
    chk("t2_a1", bus.data_out, 8'hA1);
    step();
    bus.busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold", bus.data_out, 8'hB2);
      chk("t2_hold_pv", bus.pkt_valid, 1);
      step();
    end
    bus.busy = 1'b0;
    exp_q = '{8'hB2, 8'hC3, 8'hDD};
    run_pkt("t2");

    // 3: rejects with empty buffer and with addr 3; buffer content survives
    start_pkt(2'd0);
    chk("t3_err_empty", bus.cmd_err, 1);
    chk("t3_pv_empty", bus.pkt_valid, 0);
    chk("t3_rdy_empty", bus.tx_ready, 1);
    step();
    chk("t3_err_pulse", bus.cmd_err, 0);
    load(8'h11);
    start_pkt(2'd3);
    chk("t3_err_addr3", bus.cmd_err, 1);
    chk("t3_pv_addr3", bus.pkt_valid, 0);
    chk("t3_cnt_kept", bus.ld_count, 1);
    step();
    start_pkt(2'd0);
    exp_q = '{8'h04, 8'h11, 8'h15};
    run_pkt("t3");

    // 4: overfill, full 63-byte packet to port 2
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      bus.ld_data = 8'(i);
      step();
    end
    bus.ld_valid = 1'b0;
    chk("t4_cnt", bus.ld_count, 63);
    chk("t4_full", bus.ld_full, 1);
    start_pkt(2'd2);
    exp_q = {};
    exp_q.push_back(8'hFE);
    for (int i = 0; i < 63; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hC1);
    run_pkt("t4");
    chk("t4_full0", bus.ld_full, 0);

    // 5a: busy 30 cycles from the header -> timeout
    load(8'h77);
    start_pkt(2'd1);
    chk("t5_hdr", bus.data_out, 8'h05);
    bus.busy = 1'b1;
    seen_to = 1'b0;
    for (int i = 0; i < 29; i++) begin
      step();
      seen_to |= bus.tx_timeout;
    end
    chk("t5_early_to", seen_to, 0);
    chk("t5_still_pv", bus.pkt_valid, 1);
    step();
    chk("t5_to", bus.tx_timeout, 1);
    chk("t5_pv", bus.pkt_valid, 0);
    chk("t5_dout", bus.data_out, 0);
    chk("t5_rdy", bus.tx_ready, 1);
    chk("t5_cnt", bus.ld_count, 0);
    bus.busy = 1'b0;
    step();
    chk("t5_to_pulse", bus.tx_timeout, 0);

    // 5b: busy 29 cycles -> packet completes
    load(8'h77);
    start_pkt(2'd1);
    bus.busy = 1'b1;
    seen_to = 1'b0;
    for (int i = 0; i < 29; i++) begin
      step();
      seen_to |= bus.tx_timeout;
    end
    bus.busy = 1'b0;
    chk("t5b_no_to", seen_to, 0);
    exp_q = '{8'h05, 8'h77, 8'h72};
    run_pkt("t5b");

    // 6: async reset mid-payload, then a fresh 1-byte packet
    load(8'hA1); load(8'hB2); load(8'hC3);
    start_pkt(2'd1);
    step();
    step();
    chk("t6_mid", bus.data_out, 8'hB2);
    rst = 1'b1;
    #1;
    chk("t6_rst_dout", bus.data_out, 0);
    chk("t6_rst_pv", bus.pkt_valid, 0);
    chk("t6_rst_cnt", bus.ld_count, 0);
    chk("t6_rst_rdy", bus.tx_ready, 1);
    step();
    rst = 1'b0;
    step();
    load(8'h5A);
    start_pkt(2'd0);
    exp_q = '{8'h04, 8'h5A, 8'h5E};
    run_pkt("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
